// File: rtl/qpu_lsu_ctrl.sv
// qpu_lsu_ctrl: responder end of the AGU-to-LSU ICB command channel.
// Aligned load/store commands pass straight through to the data-memory ICB
// port. Every accepted command is recorded in an in-order outstanding FIFO,
// so one writeback per command comes back carrying the original itag.
// Misaligned commands are never sent to memory. Their FIFO entry is flagged,
// and they answer with an error once they reach the head of the FIFO.

`ifndef QPU_ITAG_WIDTH
`define QPU_ITAG_WIDTH 8
`endif
`ifndef QPU_ADDR_SIZE
`define QPU_ADDR_SIZE 32
`endif
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

module qpu_lsu_ctrl #(
    parameter int OTF_DEPTH = 2,
    parameter int ITAG_W    = `QPU_ITAG_WIDTH,
    parameter int AW        = `QPU_ADDR_SIZE,
    parameter int DW        = `QPU_XLEN
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              lsu_icb_cmd_valid,
    output logic              lsu_icb_cmd_ready,
    input  logic [AW-1:0]     lsu_icb_cmd_addr,
    input  logic              lsu_icb_cmd_read,
    input  logic [DW-1:0]     lsu_icb_cmd_wdata,
    input  logic [DW/8-1:0]   lsu_icb_cmd_wmask,
    input  logic [ITAG_W-1:0] lsu_icb_cmd_itag,

    output logic              dm_icb_cmd_valid,
    input  logic              dm_icb_cmd_ready,
    output logic [AW-1:0]     dm_icb_cmd_addr,
    output logic              dm_icb_cmd_read,
    output logic [DW-1:0]     dm_icb_cmd_wdata,
    output logic [DW/8-1:0]   dm_icb_cmd_wmask,

    input  logic              dm_icb_rsp_valid,
    output logic              dm_icb_rsp_ready,
    input  logic [DW-1:0]     dm_icb_rsp_rdata,
    input  logic              dm_icb_rsp_err,

    output logic              lsu_o_valid,
    input  logic              lsu_o_ready,
    output logic [DW-1:0]     lsu_o_wbck_wdat,
    output logic [ITAG_W-1:0] lsu_o_itag,
    output logic              lsu_o_read,
    output logic              lsu_o_err,

    output logic              lsu_active
);

    // A pointer is at least one bit wide, so OTF_DEPTH = 1 still elaborates.
    // At that depth the pointer never leaves zero.
    localparam int PW = (OTF_DEPTH > 1) ? $clog2(OTF_DEPTH) : 1;
    localparam int CW = $clog2(OTF_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(OTF_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OTF_DEPTH);

    // Outstanding-entry storage: {itag, read, lerr}
    logic [ITAG_W-1:0] fifo_itag [OTF_DEPTH];
    logic              fifo_read [OTF_DEPTH];
    logic              fifo_lerr [OTF_DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic              empty;
    logic              full;
    logic              misal;
    logic              push;
    logic              pop;
    logic [ITAG_W-1:0] head_itag;
    logic              head_read;
    logic              head_lerr;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);
    assign misal = |lsu_icb_cmd_addr[1:0];

    assign head_itag = fifo_itag[rptr];
    assign head_read = fifo_read[rptr];
    assign head_lerr = fifo_lerr[rptr];

    // Command path: combinational pass-through to memory; misaligned commands are absorbed locally
    always_comb begin
        dm_icb_cmd_valid  = lsu_icb_cmd_valid & ~full & ~misal;
        lsu_icb_cmd_ready = ~full & (misal | dm_icb_cmd_ready);
        dm_icb_cmd_addr   = lsu_icb_cmd_addr;
        dm_icb_cmd_read   = lsu_icb_cmd_read;
        dm_icb_cmd_wdata  = lsu_icb_cmd_wdata;
        dm_icb_cmd_wmask  = lsu_icb_cmd_wmask;
    end

    // Response path: the FIFO head selects a local error response or a memory pass-through.
    // A memory response arriving with the FIFO empty is held off: it is never acknowledged.
    always_comb begin
        lsu_o_valid      = 1'b0;
        lsu_o_err        = 1'b0;
        lsu_o_wbck_wdat  = '0;
        dm_icb_rsp_ready = 1'b0;
        lsu_o_itag       = head_itag;
        lsu_o_read       = head_read;
        if (!empty) begin
            if (head_lerr) begin
                lsu_o_valid = 1'b1;
                lsu_o_err   = 1'b1;
            end else begin
                lsu_o_valid      = dm_icb_rsp_valid;
                dm_icb_rsp_ready = lsu_o_ready;
                lsu_o_err        = dm_icb_rsp_err;
                if (head_read && !dm_icb_rsp_err) begin
                    lsu_o_wbck_wdat = dm_icb_rsp_rdata;
                end
            end
        end
    end

    // Push is already gated by ~full through cmd_ready, so a same-cycle pop never frees a slot early
    assign push = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
    assign pop  = lsu_o_valid & lsu_o_ready;

    assign lsu_active = ~empty;

    // Entry payload write; no reset needed, since entries are only read while counted as valid
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_itag[wptr] <= lsu_icb_cmd_itag;
            fifo_read[wptr] <= lsu_icb_cmd_read;
            fifo_lerr[wptr] <= misal;
        end
    end

    // Pointer and occupancy tracking; reset discards every outstanding entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_qpu_lsu_ctrl.sv
// Self-checking bench for qpu_lsu_ctrl.
// Directed scenarios come first, then a randomized run. In the random run a
// queue-based reference model of the outstanding commands and an in-order
// memory model predict every handshake and writeback.
module tb_qpu_lsu_ctrl;

    localparam int OTF_DEPTH = 2;
    localparam int ITAG_W    = 8;
    localparam int AW        = 32;
    localparam int DW        = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              lsu_icb_cmd_valid;
    logic              lsu_icb_cmd_ready;
    logic [AW-1:0]     lsu_icb_cmd_addr;
    logic              lsu_icb_cmd_read;
    logic [DW-1:0]     lsu_icb_cmd_wdata;
    logic [DW/8-1:0]   lsu_icb_cmd_wmask;
    logic [ITAG_W-1:0] lsu_icb_cmd_itag;
    logic              dm_icb_cmd_valid;
    logic              dm_icb_cmd_ready;
    logic [AW-1:0]     dm_icb_cmd_addr;
    logic              dm_icb_cmd_read;
    logic [DW-1:0]     dm_icb_cmd_wdata;
    logic [DW/8-1:0]   dm_icb_cmd_wmask;
    logic              dm_icb_rsp_valid;
    logic              dm_icb_rsp_ready;
    logic [DW-1:0]     dm_icb_rsp_rdata;
    logic              dm_icb_rsp_err;
    logic              lsu_o_valid;
    logic              lsu_o_ready;
    logic [DW-1:0]     lsu_o_wbck_wdat;
    logic [ITAG_W-1:0] lsu_o_itag;
    logic              lsu_o_read;
    logic              lsu_o_err;
    logic              lsu_active;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [ITAG_W-1:0] itag;
        logic              read;
        logic              misal;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    qpu_lsu_ctrl #(
        .OTF_DEPTH(OTF_DEPTH), .ITAG_W(ITAG_W), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
        .lsu_icb_cmd_itag(lsu_icb_cmd_itag),
        .dm_icb_cmd_valid(dm_icb_cmd_valid), .dm_icb_cmd_ready(dm_icb_cmd_ready),
        .dm_icb_cmd_addr(dm_icb_cmd_addr), .dm_icb_cmd_read(dm_icb_cmd_read),
        .dm_icb_cmd_wdata(dm_icb_cmd_wdata), .dm_icb_cmd_wmask(dm_icb_cmd_wmask),
        .dm_icb_rsp_valid(dm_icb_rsp_valid), .dm_icb_rsp_ready(dm_icb_rsp_ready),
        .dm_icb_rsp_rdata(dm_icb_rsp_rdata), .dm_icb_rsp_err(dm_icb_rsp_err),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
        .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_itag(lsu_o_itag),
        .lsu_o_read(lsu_o_read), .lsu_o_err(lsu_o_err),
        .lsu_active(lsu_active)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        lsu_icb_cmd_valid = 1'b0;
        lsu_icb_cmd_addr  = '0;
        lsu_icb_cmd_read  = 1'b0;
        lsu_icb_cmd_wdata = '0;
        lsu_icb_cmd_wmask = '0;
        lsu_icb_cmd_itag  = '0;
        dm_icb_cmd_ready  = 1'b1;
        dm_icb_rsp_valid  = 1'b0;
        dm_icb_rsp_rdata  = '0;
        dm_icb_rsp_err    = 1'b0;
        lsu_o_ready       = 1'b1;
    endtask

    task automatic drive_cmd(input logic [AW-1:0] addr, input logic rd,
                             input logic [DW-1:0] wd, input logic [3:0] wm,
                             input logic [ITAG_W-1:0] tag);
        lsu_icb_cmd_valid = 1'b1;
        lsu_icb_cmd_addr  = addr;
        lsu_icb_cmd_read  = rd;
        lsu_icb_cmd_wdata = wd;
        lsu_icb_cmd_wmask = wm;
        lsu_icb_cmd_itag  = tag;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if ({lsu_o_valid, dm_icb_cmd_valid, lsu_active, dm_icb_rsp_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got o_valid=%0b dm_valid=%0b active=%0b rsp_ready=%0b exp all 0",
                     lsu_o_valid, dm_icb_cmd_valid, lsu_active, dm_icb_rsp_ready);
        end
        n_tests++;
        if (lsu_icb_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready got %0b exp 1", lsu_icb_cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_load();
        drive_cmd(32'h100, 1'b1, 32'h0, 4'h0, 8'd3);
        #1;
        n_tests++;
        if ({dm_icb_cmd_valid, lsu_icb_cmd_ready, dm_icb_cmd_read} !== 3'b111 || dm_icb_cmd_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL load_issue got valid=%0b ready=%0b read=%0b addr=%h exp 1 1 1 00000100",
                     dm_icb_cmd_valid, lsu_icb_cmd_ready, dm_icb_cmd_read, dm_icb_cmd_addr);
        end
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        dm_icb_rsp_valid  = 1'b1;
        dm_icb_rsp_rdata  = 32'hDEADBEEF;
        #1;
        n_tests++;
        if ({lsu_o_valid, lsu_o_read, lsu_o_err, dm_icb_rsp_ready, lsu_active} !== 5'b11011 ||
            lsu_o_wbck_wdat !== 32'hDEADBEEF || lsu_o_itag !== 8'd3) begin
            n_fail++;
            $display("FAIL load_wbck got valid=%0b read=%0b err=%0b rsp_ready=%0b active=%0b wdat=%h itag=%0d exp 1 1 0 1 1 deadbeef 3",
                     lsu_o_valid, lsu_o_read, lsu_o_err, dm_icb_rsp_ready, lsu_active, lsu_o_wbck_wdat, lsu_o_itag);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({lsu_active, lsu_o_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_idle got active=%0b o_valid=%0b exp 0 0", lsu_active, lsu_o_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_store();
        drive_cmd(32'h204, 1'b0, 32'h12345678, 4'b1111, 8'd5);
        #1;
        n_tests++;
        if (dm_icb_cmd_valid !== 1'b1 || dm_icb_cmd_addr !== 32'h204 || dm_icb_cmd_read !== 1'b0 ||
            dm_icb_cmd_wdata !== 32'h12345678 || dm_icb_cmd_wmask !== 4'b1111) begin
            n_fail++;
            $display("FAIL store_mirror got valid=%0b addr=%h read=%0b wdata=%h wmask=%b exp 1 00000204 0 12345678 1111",
                     dm_icb_cmd_valid, dm_icb_cmd_addr, dm_icb_cmd_read, dm_icb_cmd_wdata, dm_icb_cmd_wmask);
        end
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        dm_icb_rsp_valid  = 1'b1;
        dm_icb_rsp_rdata  = 32'hAAAA5555;
        #1;
        n_tests++;
        if ({lsu_o_valid, lsu_o_read, lsu_o_err} !== 3'b100 || lsu_o_wbck_wdat !== 32'h0 || lsu_o_itag !== 8'd5) begin
            n_fail++;
            $display("FAIL store_wbck got valid=%0b read=%0b err=%0b wdat=%h itag=%0d exp 1 0 0 00000000 5",
                     lsu_o_valid, lsu_o_read, lsu_o_err, lsu_o_wbck_wdat, lsu_o_itag);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        drive_cmd(32'h102, 1'b1, 32'h0, 4'h0, 8'd7);
        #1;
        n_tests++;
        if ({dm_icb_cmd_valid, lsu_icb_cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL misal_issue got dm_valid=%0b ready=%0b exp 0 1", dm_icb_cmd_valid, lsu_icb_cmd_ready);
        end
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        #1;
        n_tests++;
        if ({lsu_o_valid, lsu_o_err, dm_icb_rsp_ready} !== 3'b110 || lsu_o_wbck_wdat !== 32'h0 || lsu_o_itag !== 8'd7) begin
            n_fail++;
            $display("FAIL misal_wbck got valid=%0b err=%0b rsp_ready=%0b wdat=%h itag=%0d exp 1 1 0 00000000 7",
                     lsu_o_valid, lsu_o_err, dm_icb_rsp_ready, lsu_o_wbck_wdat, lsu_o_itag);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (lsu_active !== 1'b0) begin
            n_fail++;
            $display("FAIL misal_idle got active=%0b exp 0", lsu_active);
        end
        @(negedge clk);
    endtask

    task automatic test_ordering();
        drive_cmd(32'h300, 1'b1, 32'h0, 4'h0, 8'd1);
        @(negedge clk);
        drive_cmd(32'h301, 1'b0, 32'h99, 4'hF, 8'd2);
        #1;
        n_tests++;
        if ({dm_icb_cmd_valid, lsu_icb_cmd_ready, lsu_o_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL order_misal_issue got dm_valid=%0b ready=%0b o_valid=%0b exp 0 1 0",
                     dm_icb_cmd_valid, lsu_icb_cmd_ready, lsu_o_valid);
        end
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        #1;
        n_tests++;
        if (lsu_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL order_wait got o_valid=%0b exp 0", lsu_o_valid);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b1;
        dm_icb_rsp_rdata = 32'hCAFE0001;
        #1;
        n_tests++;
        if (lsu_o_valid !== 1'b1 || lsu_o_itag !== 8'd1 || lsu_o_err !== 1'b0 || lsu_o_wbck_wdat !== 32'hCAFE0001) begin
            n_fail++;
            $display("FAIL order_first got valid=%0b itag=%0d err=%0b wdat=%h exp 1 1 0 cafe0001",
                     lsu_o_valid, lsu_o_itag, lsu_o_err, lsu_o_wbck_wdat);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if ({lsu_o_valid, lsu_o_err, lsu_o_read} !== 3'b110 || lsu_o_itag !== 8'd2 || lsu_o_wbck_wdat !== 32'h0) begin
            n_fail++;
            $display("FAIL order_second got valid=%0b err=%0b read=%0b itag=%0d wdat=%h exp 1 1 0 2 00000000",
                     lsu_o_valid, lsu_o_err, lsu_o_read, lsu_o_itag, lsu_o_wbck_wdat);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (lsu_active !== 1'b0) begin
            n_fail++;
            $display("FAIL order_idle got active=%0b exp 0", lsu_active);
        end
        @(negedge clk);
    endtask

    task automatic test_full_backpressure();
        drive_cmd(32'h400, 1'b1, 32'h0, 4'h0, 8'd10);
        @(negedge clk);
        drive_cmd(32'h404, 1'b1, 32'h0, 4'h0, 8'd11);
        @(negedge clk);
        drive_cmd(32'h408, 1'b1, 32'h0, 4'h0, 8'd12);
        #1;
        n_tests++;
        if ({lsu_icb_cmd_ready, dm_icb_cmd_valid, lsu_active} !== 3'b001) begin
            n_fail++;
            $display("FAIL full_block got ready=%0b dm_valid=%0b active=%0b exp 0 0 1",
                     lsu_icb_cmd_ready, dm_icb_cmd_valid, lsu_active);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b1;
        dm_icb_rsp_rdata = 32'h11111111;
        lsu_o_ready      = 1'b0;
        #1;
        n_tests++;
        if ({dm_icb_rsp_ready, lsu_o_valid, lsu_icb_cmd_ready} !== 3'b010 || lsu_o_itag !== 8'd10) begin
            n_fail++;
            $display("FAIL full_hold got rsp_ready=%0b o_valid=%0b cmd_ready=%0b itag=%0d exp 0 1 0 10",
                     dm_icb_rsp_ready, lsu_o_valid, lsu_icb_cmd_ready, lsu_o_itag);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (lsu_o_valid !== 1'b1 || lsu_o_itag !== 8'd10 || lsu_o_wbck_wdat !== 32'h11111111) begin
            n_fail++;
            $display("FAIL full_stable got valid=%0b itag=%0d wdat=%h exp 1 10 11111111",
                     lsu_o_valid, lsu_o_itag, lsu_o_wbck_wdat);
        end
        @(negedge clk);
        lsu_o_ready = 1'b1;
        #1;
        n_tests++;
        if ({dm_icb_rsp_ready, lsu_icb_cmd_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_pop_no_bypass got rsp_ready=%0b cmd_ready=%0b exp 1 0",
                     dm_icb_rsp_ready, lsu_icb_cmd_ready);
        end
        @(negedge clk);
        dm_icb_rsp_rdata = 32'h22222222;
        #1;
        n_tests++;
        if ({lsu_icb_cmd_ready, dm_icb_cmd_valid} !== 2'b11 || lsu_o_itag !== 8'd11 || lsu_o_wbck_wdat !== 32'h22222222) begin
            n_fail++;
            $display("FAIL full_release got cmd_ready=%0b dm_valid=%0b itag=%0d wdat=%h exp 1 1 11 22222222",
                     lsu_icb_cmd_ready, dm_icb_cmd_valid, lsu_o_itag, lsu_o_wbck_wdat);
        end
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        dm_icb_rsp_rdata  = 32'h33333333;
        #1;
        n_tests++;
        if (lsu_o_valid !== 1'b1 || lsu_o_itag !== 8'd12 || lsu_o_wbck_wdat !== 32'h33333333) begin
            n_fail++;
            $display("FAIL full_third got valid=%0b itag=%0d wdat=%h exp 1 12 33333333",
                     lsu_o_valid, lsu_o_itag, lsu_o_wbck_wdat);
        end
        @(negedge clk);
        dm_icb_rsp_valid = 1'b0;
        #1;
        n_tests++;
        if (lsu_active !== 1'b0) begin
            n_fail++;
            $display("FAIL full_idle got active=%0b exp 0", lsu_active);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_cmd(32'h500, 1'b1, 32'h0, 4'h0, 8'd20);
        @(negedge clk);
        drive_cmd(32'h504, 1'b1, 32'h0, 4'h0, 8'd21);
        @(negedge clk);
        lsu_icb_cmd_valid = 1'b0;
        dm_icb_rsp_valid  = 1'b1;
        dm_icb_rsp_rdata  = 32'h55;
        lsu_o_ready       = 1'b0;
        #1;
        n_tests++;
        if ({lsu_o_valid, lsu_active} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_pre got o_valid=%0b active=%0b exp 1 1", lsu_o_valid, lsu_active);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({lsu_o_valid, dm_icb_cmd_valid, lsu_active, dm_icb_rsp_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async got o_valid=%0b dm_valid=%0b active=%0b rsp_ready=%0b exp all 0",
                     lsu_o_valid, dm_icb_cmd_valid, lsu_active, dm_icb_rsp_ready);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        lsu_o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({dm_icb_rsp_ready, lsu_o_valid, lsu_active} !== 3'b000) begin
                n_fail++;
                $display("FAIL rstmid_late_rsp cycle %0d got rsp_ready=%0b o_valid=%0b active=%0b exp 0 0 0",
                         i, dm_icb_rsp_ready, lsu_o_valid, lsu_active);
            end
            @(negedge clk);
        end
        dm_icb_rsp_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic          e_full, e_misal, e_cmd_ready, e_dm_valid, e_o_valid, e_rsp_ready, e_err;
        logic [DW-1:0] e_wdat;
        exp_t          h;
        mem_t          m;
        bit            gen;
        exp_q.delete();
        mem_q.delete();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            gen = (cyc < 800);
            if (!gen && exp_q.size() == 0) break;
            lsu_icb_cmd_valid = gen && ($urandom_range(0, 99) < 60);
            lsu_icb_cmd_addr  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) lsu_icb_cmd_addr[1:0] = 2'($urandom_range(1, 3));
            lsu_icb_cmd_read  = 1'($urandom_range(0, 1));
            lsu_icb_cmd_wdata = $urandom;
            lsu_icb_cmd_wmask = 4'($urandom_range(0, 15));
            lsu_icb_cmd_itag  = 8'($urandom_range(0, 255));
            dm_icb_cmd_ready  = ($urandom_range(0, 3) != 0);
            lsu_o_ready       = ($urandom_range(0, 3) != 0);
            dm_icb_rsp_valid  = (mem_q.size() > 0) && ($urandom_range(0, 2) != 0);
            if (dm_icb_rsp_valid) begin
                dm_icb_rsp_rdata = mem_q[0].rdata;
                dm_icb_rsp_err   = mem_q[0].err;
            end else begin
                dm_icb_rsp_rdata = $urandom;
                dm_icb_rsp_err   = 1'($urandom_range(0, 1));
            end
            #1;
            e_full      = (exp_q.size() >= OTF_DEPTH);
            e_misal     = (lsu_icb_cmd_addr[1:0] != 2'b00);
            e_cmd_ready = !e_full && (e_misal || dm_icb_cmd_ready);
            e_dm_valid  = lsu_icb_cmd_valid && !e_full && !e_misal;
            e_o_valid   = 1'b0;
            e_rsp_ready = 1'b0;
            e_err       = 1'b0;
            e_wdat      = '0;
            h           = '0;
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                if (h.misal) begin
                    e_o_valid = 1'b1;
                    e_err     = 1'b1;
                end else begin
                    e_o_valid   = dm_icb_rsp_valid;
                    e_rsp_ready = lsu_o_ready;
                    e_err       = dm_icb_rsp_err;
                    e_wdat      = (h.read && !dm_icb_rsp_err) ? dm_icb_rsp_rdata : '0;
                end
            end
            n_tests++;
            if ({lsu_icb_cmd_ready, dm_icb_cmd_valid, lsu_o_valid, dm_icb_rsp_ready, lsu_active} !==
                {e_cmd_ready, e_dm_valid, e_o_valid, e_rsp_ready, (exp_q.size() != 0)}) begin
                n_fail++;
                $display("FAIL rand_hs cycle %0d got cmd_rdy/dm_vld/o_vld/rsp_rdy/active=%b exp %b",
                         cyc, {lsu_icb_cmd_ready, dm_icb_cmd_valid, lsu_o_valid, dm_icb_rsp_ready, lsu_active},
                         {e_cmd_ready, e_dm_valid, e_o_valid, e_rsp_ready, (exp_q.size() != 0)});
            end
            if (e_o_valid) begin
                n_tests++;
                if (lsu_o_itag !== h.itag || lsu_o_read !== h.read || lsu_o_err !== e_err || lsu_o_wbck_wdat !== e_wdat) begin
                    n_fail++;
                    $display("FAIL rand_wbck cycle %0d got itag=%0d read=%0b err=%0b wdat=%h exp %0d %0b %0b %h",
                             cyc, lsu_o_itag, lsu_o_read, lsu_o_err, lsu_o_wbck_wdat, h.itag, h.read, e_err, e_wdat);
                end
            end
            if (e_dm_valid) begin
                n_tests++;
                if (dm_icb_cmd_addr !== lsu_icb_cmd_addr || dm_icb_cmd_wdata !== lsu_icb_cmd_wdata ||
                    dm_icb_cmd_wmask !== lsu_icb_cmd_wmask || dm_icb_cmd_read !== lsu_icb_cmd_read) begin
                    n_fail++;
                    $display("FAIL rand_dm_cmd cycle %0d got addr=%h wdata=%h exp %h %h",
                             cyc, dm_icb_cmd_addr, dm_icb_cmd_wdata, lsu_icb_cmd_addr, lsu_icb_cmd_wdata);
                end
            end
            if (e_o_valid && lsu_o_ready) void'(exp_q.pop_front());
            if (dm_icb_rsp_valid && e_rsp_ready) void'(mem_q.pop_front());
            if (lsu_icb_cmd_valid && e_cmd_ready) begin
                exp_q.push_back('{itag: lsu_icb_cmd_itag, read: lsu_icb_cmd_read, misal: e_misal});
                if (!e_misal) begin
                    m.rdata = $urandom;
                    m.err   = ($urandom_range(0, 7) == 0);
                    mem_q.push_back(m);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        n_tests++;
        if (lsu_active !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain got active=%0b model_outstanding=%0d exp 0 0", lsu_active, exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_aligned_load();
        test_store();
        test_misaligned();
        test_ordering();
        test_full_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qpu_lsu_ctrl.md
Name: qpu_lsu_ctrl

Overview:
- LSU control block: the responder end of the AGU-to-LSU ICB command channel.
- Accepts aligned load/store commands tagged with an instruction tag (itag) and forwards them to the data-memory ICB port.
- Tracks outstanding transactions in an in-order FIFO and returns one writeback response per command, carrying the original itag, to the long-pipe writeback stage.
- Detects misaligned addresses locally and answers them with an error response; such commands are never forwarded to memory.

Parameters:
- OTF_DEPTH, 2: maximum outstanding (issued, not yet responded) commands; power of two, at least 1.
- ITAG_W, `QPU_ITAG_WIDTH: itag width.
- AW, `QPU_ADDR_SIZE: address width.
- DW, `QPU_XLEN (32): data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu_icb_cmd_valid  in  1  command valid from AGU
- lsu_icb_cmd_ready  out  1  command ready to AGU
- lsu_icb_cmd_addr  in  AW  byte address
- lsu_icb_cmd_read  in  1  1 = load, 0 = store
- lsu_icb_cmd_wdata  in  DW  store data
- lsu_icb_cmd_wmask  in  DW/8  byte mask
- lsu_icb_cmd_itag  in  ITAG_W  instruction tag
- dm_icb_cmd_valid  out  1  memory command valid
- dm_icb_cmd_ready  in  1  memory command ready
- dm_icb_cmd_addr  out  AW  memory address
- dm_icb_cmd_read  out  1  memory read/write
- dm_icb_cmd_wdata  out  DW  memory write data
- dm_icb_cmd_wmask  out  DW/8  memory byte mask
- dm_icb_rsp_valid  in  1  memory response valid
- dm_icb_rsp_ready  out  1  memory response ready
- dm_icb_rsp_rdata  in  DW  memory read data
- dm_icb_rsp_err  in  1  memory bus error
- lsu_o_valid  out  1  writeback valid
- lsu_o_ready  in  1  writeback ready
- lsu_o_wbck_wdat  out  DW  load data; 0 for stores and errors
- lsu_o_itag  out  ITAG_W  tag of the responding command
- lsu_o_read  out  1  1 = load, so writeback writes the destination register
- lsu_o_err  out  1  bus error or misaligned access
- lsu_active  out  1  1 when any transaction is outstanding

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous and active-low.
- Reset state: FIFO read/write pointers and count = 0. All valid outputs = 0 and lsu_active = 0 (all derived from empty FIFO). Reset mid-transaction discards every outstanding entry; memory responses arriving after reset are not forwarded (dm_icb_rsp_ready = 0 while the FIFO is empty).
- OTF FIFO: entry = {itag, read, lerr}, where lerr = (addr[1:0] != 0). full = (count == OTF_DEPTH). Pointers wrap modulo OTF_DEPTH.
- Command path (combinational pass-through):
  - misal = lsu_icb_cmd_addr[1:0] != 0.
  - dm_icb_cmd_valid = lsu_icb_cmd_valid & ~full & ~misal.
  - lsu_icb_cmd_ready = ~full & (misal | dm_icb_cmd_ready).
  - dm_icb_cmd_addr/read/wdata/wmask = corresponding lsu_icb_cmd_* fields.
  - Push on lsu_icb_cmd_valid & lsu_icb_cmd_ready.
- full blocks push even when a pop happens in the same cycle (no bypass).
- Response path (head entry H, FIFO non-empty):
  - If H.lerr: lsu_o_valid = 1, lsu_o_err = 1, lsu_o_wbck_wdat = 0; dm_icb_rsp_ready = 0.
  - Else: lsu_o_valid = dm_icb_rsp_valid, dm_icb_rsp_ready = lsu_o_ready, lsu_o_err = dm_icb_rsp_err, lsu_o_wbck_wdat = (H.read & ~dm_icb_rsp_err) ? dm_icb_rsp_rdata : 0.
  - lsu_o_itag = H.itag; lsu_o_read = H.read.
  - Pop on lsu_o_valid & lsu_o_ready.
- FIFO empty: lsu_o_valid = 0, dm_icb_rsp_ready = 0. A memory response received while empty is a protocol violation; it is held off, never acknowledged.
- Ordering: responses are returned strictly in command order; the memory returns responses in order. A misaligned entry waits at the FIFO tail until it reaches the head.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Latency: command is 0-cycle combinational pass-through; response is 0-cycle pass-through. Minimum issue-to-writeback latency equals memory latency.
- lsu_active = (count != 0).

Test Plan:
- Aligned load: addr 0x100, itag 3; memory returns rdata 0xDEADBEEF one cycle later -> lsu_o_valid with wbck_wdat 0xDEADBEEF, itag 3, read 1, err 0; lsu_active returns to 0.
- Store: addr 0x204, wdata 0x12345678, wmask 4'b1111 -> dm_icb_cmd mirrors all fields; response gives lsu_o_read 0, wbck_wdat 0, err 0.
- Misaligned load at 0x102 -> no dm_icb_cmd_valid; lsu_o_valid asserted next cycle with err 1, wbck_wdat 0.
- Ordering: aligned load (itag 1, memory delayed 3 cycles) then misaligned store (itag 2) -> itag 1 written back first, itag 2 the following cycle.
- Full/backpressure (OTF_DEPTH = 2): issue 3 loads with no memory response -> third sees lsu_icb_cmd_ready = 0 until the first writeback; hold lsu_o_ready = 0 -> dm_icb_rsp_ready = 0 and the response is held stable.
- Reset mid-operation: rst_n low with 2 entries outstanding -> lsu_o_valid, dm_icb_cmd_valid and lsu_active drop to 0 immediately (asynchronously); a late dm rsp is not acknowledged.
